cpu_microsequencer: RTL and testbench

Parametrised microcode address sequencer for the 6502-family CPU cores. It is the next-generation replacement for the inline next-address logic, and adds:
- a microcode call/return stack
- opcode dispatch with interrupt injection at instruction fetch
- NMI edge detection and IRQ level detection
- a sticky halt state for KIL opcodes

It sits between the microcode ROM (which supplies sequence op, branch target and branch polarity) and the ROM address input.

---
 rtl/cpu_microsequencer_pkg.sv | 26 ++
 rtl/cpu_microsequencer_stack.sv | 60 ++++++
 rtl/cpu_microsequencer.sv | 147 ++++++++++++++
 tb/tb_cpu_microsequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_microsequencer_pkg.sv
// Shared microcode constants: sequence-op encodings, interrupt acknowledge
// codes and the default microcode entry points.
package cpu_microsequencer_pkg;

  localparam logic [2:0] SEQ_NEXT     = 3'd0;
  localparam logic [2:0] SEQ_BRANCH   = 3'd1;
  localparam logic [2:0] SEQ_DISPATCH = 3'd2;
  localparam logic [2:0] SEQ_FETCH    = 3'd3;
  localparam logic [2:0] SEQ_CALL     = 3'd4;
  localparam logic [2:0] SEQ_RETURN   = 3'd5;
  localparam logic [2:0] SEQ_HALT     = 3'd6;
  localparam logic [2:0] SEQ_RSVD     = 3'd7;

  localparam logic [1:0] ACK_NONE = 2'b00;
  localparam logic [1:0] ACK_IRQ  = 2'b01;
  localparam logic [1:0] ACK_NMI  = 2'b10;

  localparam int unsigned DEF_RESET_ADDR = 'h300;
  localparam int unsigned DEF_NMI_ADDR   = 'h310;
  localparam int unsigned DEF_IRQ_ADDR   = 'h320;

  function automatic logic branch_taken(input logic cond, input logic pol);
    return cond == pol;
  endfunction

endpackage

// File: rtl/cpu_microsequencer_stack.sv
// Microcode return-address LIFO. A push into a full stack or a pop from an
// empty one is ignored; the caller owns the error reporting.
module cpu_microsequencer_stack
  import cpu_microsequencer_pkg::*;
#(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [W-1:0]                   din,
  output logic [W-1:0]                   dout,
  output logic [$clog2(DEPTH+1)-1:0]     depth,
  output logic                           full,
  output logic                           empty
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [0:DEPTH-1];
  logic [DW-1:0] depth_q;
  logic [DW-1:0] depth_d;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx = depth_q[AW-1:0];
  assign rd_idx = wr_idx - AW'(1);
  assign full   = (depth_q == DW'(DEPTH));
  assign empty  = (depth_q == '0);
  assign depth  = depth_q;
  assign dout   = mem_q[rd_idx];

  always_comb begin
    depth_d = depth_q;
    if (push && !full) begin
      depth_d = depth_q + DW'(1);
    end else if (pop && !empty) begin
      depth_d = depth_q - DW'(1);
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  // Contents are not cleared on reset; depth alone defines validity.
  always_ff @(negedge clock) begin
    if (push && !full) begin
      mem_q[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/cpu_microsequencer.sv
// Microcode next-address sequencer: next/branch/dispatch/fetch/call/return/halt,
// with NMI edge detection, IRQ level sampling at fetch and sticky error flags.
module cpu_microsequencer
  import cpu_microsequencer_pkg::*;
#(
  parameter int                 UADDR_W       = 10,
  parameter int                 OPCODE_W      = 8,
  parameter int unsigned        DISPATCH_PAGE = 1,
  parameter int                 STACK_DEPTH   = 4,
  parameter logic [UADDR_W-1:0] RESET_ADDR    = UADDR_W'(DEF_RESET_ADDR),
  parameter logic [UADDR_W-1:0] NMI_ADDR      = UADDR_W'(DEF_NMI_ADDR),
  parameter logic [UADDR_W-1:0] IRQ_ADDR      = UADDR_W'(DEF_IRQ_ADDR)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enable,
  input  logic [2:0]                         seq_op,
  input  logic [UADDR_W-1:0]                 branch_addr,
  input  logic                               branch_pol,
  input  logic                               cond_in,
  input  logic [OPCODE_W-1:0]                opcode,
  input  logic                               nmi_n,
  input  logic                               irq_n,
  input  logic                               irq_mask,
  output logic [UADDR_W-1:0]                 uaddr,
  output logic [1:0]                         int_ack,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
  output logic                               err_overflow,
  output logic                               err_underflow,
  output logic                               halted
);

  localparam int PW = UADDR_W - OPCODE_W;
  localparam logic [PW-1:0] PAGE = PW'(DISPATCH_PAGE);

  logic [UADDR_W-1:0] uaddr_q, uaddr_d;
  logic [1:0]         int_ack_q, int_ack_d;
  logic               err_ovf_q, err_ovf_d;
  logic               err_unf_q, err_unf_d;
  logic               halted_q, halted_d;
  logic               nmi_pending_q, nmi_pending_d;
  logic               nmi_n_prev_q, nmi_n_prev_d;

  logic               stk_push, stk_pop, stk_full, stk_empty;
  logic [UADDR_W-1:0] stk_dout;
  logic [UADDR_W-1:0] uaddr_inc;
  logic [UADDR_W-1:0] dispatch_addr;
  logic               nmi_edge;

  assign uaddr_inc     = uaddr_q + UADDR_W'(1);
  assign dispatch_addr = {PAGE, opcode};
  assign nmi_edge      = nmi_n_prev_q && !nmi_n;

  cpu_microsequencer_stack #(
    .W     (UADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock (clock),
    .reset (reset),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (uaddr_inc),
    .dout  (stk_dout),
    .depth (stack_depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    uaddr_d       = uaddr_q;
    int_ack_d     = int_ack_q;
    err_ovf_d     = err_ovf_q;
    err_unf_d     = err_unf_q;
    halted_d      = halted_q;
    nmi_pending_d = nmi_pending_q;
    nmi_n_prev_d  = nmi_n_prev_q;
    stk_push      = 1'b0;
    stk_pop       = 1'b0;
    if (enable) begin
      int_ack_d    = ACK_NONE;
      nmi_n_prev_d = nmi_n;
      if (!halted_q) begin
        case (seq_op)
          SEQ_BRANCH:   uaddr_d = branch_taken(cond_in, branch_pol) ? branch_addr : uaddr_inc;
          SEQ_DISPATCH: uaddr_d = dispatch_addr;
          SEQ_FETCH: begin
            if (nmi_pending_q) begin
              uaddr_d       = NMI_ADDR;
              nmi_pending_d = 1'b0;
              int_ack_d     = ACK_NMI;
            end else if (!irq_n && !irq_mask) begin
              uaddr_d   = IRQ_ADDR;
              int_ack_d = ACK_IRQ;
            end else begin
              uaddr_d = dispatch_addr;
            end
          end
          SEQ_CALL: begin
            stk_push = 1'b1;
            uaddr_d  = branch_addr;
            if (stk_full) err_ovf_d = 1'b1;
          end
          SEQ_RETURN: begin
            if (stk_empty) begin
              uaddr_d   = RESET_ADDR;
              err_unf_d = 1'b1;
            end else begin
              stk_pop = 1'b1;
              uaddr_d = stk_dout;
            end
          end
          SEQ_HALT: halted_d = 1'b1;
          default:  uaddr_d = uaddr_inc;
        endcase
      end
      // A new edge beats the clear from an NMI fetch in the same cycle.
      if (nmi_edge) nmi_pending_d = 1'b1;
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      uaddr_q       <= RESET_ADDR;
      int_ack_q     <= ACK_NONE;
      err_ovf_q     <= 1'b0;
      err_unf_q     <= 1'b0;
      halted_q      <= 1'b0;
      nmi_pending_q <= 1'b0;
      nmi_n_prev_q  <= 1'b1;
    end else begin
      uaddr_q       <= uaddr_d;
      int_ack_q     <= int_ack_d;
      err_ovf_q     <= err_ovf_d;
      err_unf_q     <= err_unf_d;
      halted_q      <= halted_d;
      nmi_pending_q <= nmi_pending_d;
      nmi_n_prev_q  <= nmi_n_prev_d;
    end
  end

  assign uaddr         = uaddr_q;
  assign int_ack       = int_ack_q;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_cpu_microsequencer.sv
// Bench for cpu_microsequencer: directed scenarios with literal expectations,
// then randomized traffic, all tracked by a queue-based behavioural model.
module tb_cpu_microsequencer;

  logic       clock, reset, enable;
  logic [2:0] seq_op;
  logic [9:0] branch_addr;
  logic       branch_pol, cond_in;
  logic [7:0] opcode;
  logic       nmi_n, irq_n, irq_mask;
  logic [9:0] uaddr;
  logic [1:0] int_ack;
  logic [2:0] stack_depth;
  logic       err_overflow, err_underflow, halted;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  int m_uaddr, m_ack;
  bit m_ovf, m_unf, m_halt, m_pend, m_prev;
  int m_stack[$];

  cpu_microsequencer dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .seq_op        (seq_op),
    .branch_addr   (branch_addr),
    .branch_pol    (branch_pol),
    .cond_in       (cond_in),
    .opcode        (opcode),
    .nmi_n         (nmi_n),
    .irq_n         (irq_n),
    .irq_mask      (irq_mask),
    .uaddr         (uaddr),
    .int_ack       (int_ack),
    .stack_depth   (stack_depth),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .halted        (halted)
  );

  // clock / reset
  initial clock = 1'b1;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_uaddr = 'h300; m_ack = 0; m_ovf = 0; m_unf = 0;
    m_halt = 0; m_pend = 0; m_prev = 1;
    m_stack.delete();
  endtask

  // Called shortly after a rising edge; releases reset after the next falling edge.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic tick();
    @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input logic [2:0] o, input logic [9:0] a);
    seq_op = o; branch_addr = a; branch_pol = 1'b1; cond_in = 1'b1;
  endtask

  // reference model: one microinstruction per enabled falling edge
  always @(negedge clock) begin
    bit edge_seen;
    if (!reset && enable) begin
      edge_seen = m_prev && !nmi_n;
      m_prev = nmi_n;
      m_ack = 0;
      if (!m_halt) begin
        case (int'(seq_op))
          1: m_uaddr = (cond_in == branch_pol) ? int'(branch_addr) : (m_uaddr + 1) % 1024;
          2: m_uaddr = 256 + int'(opcode);
          3: begin
            if (m_pend) begin
              m_uaddr = 'h310; m_pend = 0; m_ack = 2;
            end else if (!irq_n && !irq_mask) begin
              m_uaddr = 'h320; m_ack = 1;
            end else begin
              m_uaddr = 256 + int'(opcode);
            end
          end
          4: begin
            if (m_stack.size() == 4) m_ovf = 1;
            else m_stack.push_back((m_uaddr + 1) % 1024);
            m_uaddr = int'(branch_addr);
          end
          5: begin
            if (m_stack.size() == 0) begin
              m_uaddr = 'h300; m_unf = 1;
            end else begin
              m_uaddr = m_stack.pop_back();
            end
          end
          6: m_halt = 1;
          default: m_uaddr = (m_uaddr + 1) % 1024;
        endcase
      end
      if (edge_seen) m_pend = 1;
    end
  end

  // scoreboard compare: outputs settle after the falling edge, sampled on the rising one
  always @(posedge clock) begin
    if (!reset) begin
      check("uaddr",       int'(uaddr),         m_uaddr);
      check("int_ack",     int'(int_ack),       m_ack);
      check("stack_depth", int'(stack_depth),   m_stack.size());
      check("err_ovf",     int'(err_overflow),  int'(m_ovf));
      check("err_unf",     int'(err_underflow), int'(m_unf));
      check("halted",      int'(halted),        int'(m_halt));
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b1; seq_op = 3'd0; branch_addr = '0;
    branch_pol = 1'b0; cond_in = 1'b0; opcode = '0;
    nmi_n = 1'b1; irq_n = 1'b1; irq_mask = 1'b1;
    model_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    #1;

    check("lit_reset_uaddr", int'(uaddr), 'h300);
    check("lit_reset_ack", int'(int_ack), 0);
    check("lit_reset_depth", int'(stack_depth), 0);
    check("lit_reset_flags", int'({err_overflow, err_underflow, halted}), 0);

    for (int i = 1; i <= 3; i++) begin
      set_op(3'd0, '0); tick();
      check("lit_next", int'(uaddr), 'h300 + i);
    end
    set_op(3'd1, 10'h3FF); tick();
    check("lit_branch_3ff", int'(uaddr), 'h3FF);
    set_op(3'd0, '0); tick();
    check("lit_next_wrap", int'(uaddr), 'h000);

    set_op(3'd1, 10'h155); tick();
    check("lit_branch_taken", int'(uaddr), 'h155);
    cond_in = 1'b0; tick();
    check("lit_branch_not_taken", int'(uaddr), 'h156);

    set_op(3'd3, '0); opcode = 8'hA9; irq_n = 1'b1; irq_mask = 1'b0; tick();
    check("lit_fetch_dispatch", int'(uaddr), 'h1A9);
    nmi_n = 1'b0; set_op(3'd0, '0); tick();
    irq_n = 1'b0; set_op(3'd3, '0); tick();
    check("lit_nmi_addr", int'(uaddr), 'h310);
    check("lit_nmi_ack", int'(int_ack), 2);
    set_op(3'd0, '0); tick();
    check("lit_ack_pulse_end", int'(int_ack), 0);
    set_op(3'd3, '0); tick();
    check("lit_irq_addr", int'(uaddr), 'h320);
    check("lit_irq_ack", int'(int_ack), 1);
    irq_mask = 1'b1; tick();
    check("lit_irq_masked", int'(uaddr), 'h1A9);

    // new NMI edge coinciding with an NMI fetch keeps the request pending
    nmi_n = 1'b1; set_op(3'd0, '0); tick();
    nmi_n = 1'b0; tick();
    nmi_n = 1'b1; tick();
    nmi_n = 1'b0; set_op(3'd3, '0); tick();
    check("lit_nmi_coincide_1", int'(uaddr), 'h310);
    tick();
    check("lit_nmi_coincide_2", int'(uaddr), 'h310);
    tick();
    check("lit_nmi_consumed", int'(uaddr), 'h1A9);
    nmi_n = 1'b1; irq_n = 1'b1;

    set_op(3'd1, 10'h050); tick();
    for (int i = 0; i < 5; i++) begin
      set_op(3'd4, 10'h200); tick();
    end
    check("lit_call_depth", int'(stack_depth), 4);
    check("lit_call_ovf", int'(err_overflow), 1);
    check("lit_call_uaddr", int'(uaddr), 'h200);
    for (int i = 0; i < 4; i++) begin
      set_op(3'd5, '0); tick();
      check("lit_return", int'(uaddr), (i == 3) ? 'h051 : 'h201);
    end
    tick();
    check("lit_underflow_uaddr", int'(uaddr), 'h300);
    check("lit_underflow_flag", int'(err_underflow), 1);

    set_op(3'd1, 10'h0F0); tick();
    set_op(3'd6, '0); tick();
    check("lit_halted", int'(halted), 1);
    for (int i = 0; i < 10; i++) begin
      seq_op = 3'($urandom_range(0, 7));
      branch_addr = 10'($urandom_range(0, 1023));
      nmi_n = (i == 3 || i == 4) ? 1'b0 : 1'b1;
      tick();
      check("lit_halt_hold", int'(uaddr), 'h0F0);
    end
    nmi_n = 1'b1;
    do_reset();
    check("lit_halt_reset_uaddr", int'(uaddr), 'h300);
    check("lit_halt_reset_flag", int'(halted), 0);
    set_op(3'd3, '0); opcode = 8'h12; irq_mask = 1'b1; tick();
    check("lit_no_stale_nmi", int'(uaddr), 'h112);

    irq_n = 1'b0; irq_mask = 1'b0; tick();
    check("lit_irq_before_freeze", int'(int_ack), 1);
    enable = 1'b0; set_op(3'd0, '0);
    for (int i = 0; i < 5; i++) begin
      nmi_n = (i == 1 || i == 2) ? 1'b0 : 1'b1;
      tick();
      check("lit_freeze_uaddr", int'(uaddr), 'h320);
      check("lit_freeze_ack", int'(int_ack), 1);
    end
    enable = 1'b1; irq_n = 1'b1; irq_mask = 1'b1; nmi_n = 1'b1;
    set_op(3'd3, '0); opcode = 8'h34; tick();
    check("lit_frozen_nmi_ignored", int'(uaddr), 'h134);
    check("lit_ack_cleared", int'(int_ack), 0);

    for (int i = 0; i < 600; i++) begin
      seq_op = 3'($urandom_range(0, 7));
      if (seq_op == 3'd6 && $urandom_range(0, 15) != 0) seq_op = 3'd0;
      branch_addr = 10'($urandom_range(0, 1023));
      branch_pol  = 1'($urandom_range(0, 1));
      cond_in     = 1'($urandom_range(0, 1));
      opcode      = 8'($urandom_range(0, 255));
      nmi_n       = ($urandom_range(0, 3) != 0);
      irq_n       = ($urandom_range(0, 3) != 0);
      irq_mask    = 1'($urandom_range(0, 1));
      enable      = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 60) == 0 || (m_halt && $urandom_range(0, 7) == 0)) begin
        #($urandom_range(0, 3));
        do_reset();
      end else begin
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
